audio_out_mixer: RTL and testbench

AUDIO_OUT_MIXER -- requirements
Module: audio_out_mixer

---
 rtl/audio_out_mixer.sv | 106 ++++++++++
 tb/tb_audio_out_mixer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_out_mixer.sv
// Eight-voice mixer with master attenuation and saturation, feeding a codec FIFO
// at a fixed sample rate through a one-deep, newest-wins output buffer.
module audio_out_mixer #(
  parameter int unsigned SAMPLE_DIV = 1042,
  parameter logic [31:0] SAT_MAX    = 32'h7FFFFFFF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [255:0] voice_in,
  input  logic [7:0]   voice_en,
  input  logic [2:0]   vol_shift,
  input  logic         audio_out_allowed,
  output logic [31:0]  left_audio_out,
  output logic [31:0]  right_audio_out,
  output logic         write_audio_out,
  output logic [7:0]   overrun_count
);

  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        tick_cnt;
  logic               tick;
  logic signed [34:0] voice_sum;
  logic signed [34:0] s1;
  logic [2:0]         s1_shift;
  logic               s1_valid;
  logic signed [34:0] shifted;
  logic signed [34:0] sat_hi;
  logic signed [34:0] sat_lo;
  logic [31:0]        s2_sample;
  logic [31:0]        pending;
  logic               pending_valid;

  assign tick = (tick_cnt == 16'(SAMPLE_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + 16'd1;
  end

  always_comb begin
    voice_sum = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (voice_en[k])
        voice_sum = voice_sum + $signed({{3{voice_in[32*k+31]}}, voice_in[32*k +: 32]});
    end
  end

  // Stage 1: raw 35-bit sum with the attenuation captured at the same tick
  always_ff @(posedge clock) begin
    if (reset) begin
      s1       <= '0;
      s1_shift <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= tick;
      if (tick) begin
        s1       <= voice_sum;
        s1_shift <= vol_shift;
      end
    end
  end

  // Stage 2: shift first, then clamp, so attenuation can pull an overflowing sum back in range
  assign shifted = s1 >>> s1_shift;
  assign sat_hi  = $signed({3'b000, SAT_MAX});
  assign sat_lo  = -sat_hi - 35'sd1;

  always_comb begin
    if (shifted > sat_hi)      s2_sample = sat_hi[31:0];
    else if (shifted < sat_lo) s2_sample = sat_lo[31:0];
    else                       s2_sample = shifted[31:0];
  end

  // A held sample exists exactly while the FSM waits for FIFO space
  assign pending_valid = (state_q == WAIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      pending       <= '0;
      overrun_count <= '0;
    end else begin
      state_q <= state_d;
      if (s1_valid) pending <= s2_sample;
      if (s1_valid && pending_valid && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s1_valid) state_d = WAIT;
      WAIT:    if (audio_out_allowed) state_d = WRITE;
      WRITE:   state_d = s1_valid ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign write_audio_out = (state_q == WRITE);
  assign left_audio_out  = pending;
  assign right_audio_out = pending;

endmodule

// File: tb/tb_audio_out_mixer.sv
// Scoreboard bench for audio_out_mixer at SAMPLE_DIV=8: expected samples are queued
// at each tick from the driven inputs and retired against every write strobe.
module tb_audio_out_mixer;
  localparam int SD = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] voice_in = '0;
  logic [7:0]   voice_en = '0;
  logic [2:0]   vol_shift = '0;
  logic         audio_out_allowed = 1'b1;
  logic [31:0]  left_audio_out, right_audio_out;
  logic         write_audio_out;
  logic [7:0]   overrun_count;

  typedef struct {
    logic signed [31:0] val;
    int                 tick;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   strobes = 0;
  int   pushed = 0;
  bit   chk_lat = 1'b0;
  bit   prev_wr = 1'b0;

  audio_out_mixer #(.SAMPLE_DIV(SD)) dut (
    .clock(clock), .reset(reset), .voice_in(voice_in), .voice_en(voice_en),
    .vol_shift(vol_shift), .audio_out_allowed(audio_out_allowed),
    .left_audio_out(left_audio_out), .right_audio_out(right_audio_out),
    .write_audio_out(write_audio_out), .overrun_count(overrun_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic signed [31:0] model_sample(input logic [255:0] vi,
                                                      input logic [7:0] en,
                                                      input logic [2:0] sh);
    longint acc = 0;
    for (int k = 0; k < 8; k++)
      if (en[k]) acc += longint'($signed(vi[32*k +: 32]));
    acc = acc >>> sh;
    if (acc > 64'sd2147483647)       acc = 64'sd2147483647;
    else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    return acc[31:0];
  endfunction

  // Predictor: runs after the drivers settle in each tick cycle
  always @(negedge clock) begin
    #1;
    if (reset == 1'b0 && (cyc % SD) == SD - 1) begin
      exp_q.push_back('{val: model_sample(voice_in, voice_en, vol_shift), tick: cyc});
      pushed++;
    end
  end

  // Monitor: retires one expected sample per strobe
  always @(negedge clock) begin
    exp_t e;
    #2;
    if (write_audio_out === 1'b1) begin
      strobes++;
      checks++;
      if (prev_wr) begin
        errors++;
        $display("FAIL strobe_width: cyc=%0d strobe high two cycles running, required one", cyc);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: cyc=%0d sample=%0d, required no strobe",
                 cyc, $signed(left_audio_out));
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ($signed(left_audio_out) !== e.val) begin
          errors++;
          $display("FAIL sample_value: cyc=%0d got %0d, required %0d", cyc, $signed(left_audio_out), e.val);
        end
        checks++;
        if (right_audio_out !== left_audio_out) begin
          errors++;
          $display("FAIL right_eq_left: right=%0d, required %0d", $signed(right_audio_out), $signed(left_audio_out));
        end
        if (chk_lat) begin
          checks++;
          if (cyc !== e.tick + 3) begin
            errors++;
            $display("FAIL latency: strobe at cyc %0d, required %0d", cyc, e.tick + 3);
          end
        end
      end
    end
    prev_wr = (write_audio_out === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  task automatic set_all(input int v, input logic [7:0] en, input logic [2:0] sh);
    for (int k = 0; k < 8; k++) voice_in[32*k +: 32] = v;
    voice_en  = en;
    vol_shift = sh;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 2 * SD; i++) begin
      @(negedge clock);
      if ((cyc % SD) == SD - 1) break;
    end
  endtask

  task automatic test_reset();
    set_all(123456, 8'hFF, 3'd0);
    audio_out_allowed = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (left_audio_out !== 32'd0) begin errors++; $display("FAIL reset_left: got %0d, required 0", left_audio_out); end
    checks++; if (right_audio_out !== 32'd0) begin errors++; $display("FAIL reset_right: got %0d, required 0", right_audio_out); end
    checks++; if (write_audio_out !== 1'b0) begin errors++; $display("FAIL reset_write: got %b, required 0", write_audio_out); end
    checks++; if (overrun_count !== 8'd0) begin errors++; $display("FAIL reset_overrun: got %0d, required 0", overrun_count); end
  endtask

  task automatic test_basic();
    int s0;
    set_all(0, 8'h03, 3'd0);
    voice_in[31:0]  = 32'd300000000;
    voice_in[63:32] = 32'd300000000;
    voice_in[95:64] = 32'd777;
    audio_out_allowed = 1'b1;
    chk_lat = 1'b1;
    do_reset();
    s0 = strobes;
    repeat (44) @(negedge clock);
    checks++;
    if (strobes - s0 !== 5) begin errors++; $display("FAIL basic_strobe_count: got %0d, required 5", strobes - s0); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_queue: %0d samples outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_saturate();
    bit ok;
    int vals[4] = '{300000000, -300000000, 300000000, -1001};
    logic [2:0] shs[4] = '{3'd0, 3'd0, 3'd1, 3'd3};
    logic [7:0] ens[4] = '{8'hFF, 8'hFF, 8'hFF, 8'h01};
    for (int i = 0; i < 4; i++) begin
      set_all(vals[i], ens[i], shs[i]);
      repeat (16) @(negedge clock);
      drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL saturate_drain: case %0d samples not written, required all", i); end
    end
  endtask

  task automatic test_shift_carry();
    bit ok;
    set_all(-700000000, 8'h0F, 3'd2);
    wait_tick();
    @(negedge clock);
    vol_shift = 3'd0;
    set_all(5, 8'h0F, 3'd0);
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL shift_carry_drain: queue not empty, required empty"); end
  endtask

  task automatic test_disabled();
    bit ok;
    int s0, p0;
    set_all(-42, 8'h00, 3'd0);
    repeat (12) @(negedge clock);
    drain(ok);
    s0 = strobes;
    p0 = pushed;
    repeat (24) @(negedge clock);
    drain(ok);
    checks++;
    if (!ok || strobes - s0 !== pushed - p0 || strobes == s0) begin
      errors++;
      $display("FAIL disabled_strobes: got %0d strobes, required %0d (nonzero)", strobes - s0, pushed - p0);
    end
  endtask

  task automatic test_allowed_drop_in_write();
    bit ok;
    set_all(1000, 8'h80, 3'd0);
    wait_tick();
    repeat (3) @(negedge clock);
    audio_out_allowed = 1'b0;
    @(negedge clock);
    audio_out_allowed = 1'b1;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_not_cancelled: sample not written, required written"); end
  endtask

  task automatic test_overrun();
    bit ok;
    int s0;
    set_all(0, 8'h01, 3'd0);
    audio_out_allowed = 1'b0;
    chk_lat = 1'b0;
    do_reset();
    s0 = strobes;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clock);
      voice_in[31:0] = 32'(cyc * 1000 + 1);
      if (c == 29) begin
        checks++;
        if (overrun_count !== 8'd2) begin errors++; $display("FAIL overrun_count: got %0d, required 2", overrun_count); end
        checks++;
        if (strobes != s0) begin errors++; $display("FAIL overrun_stall: got %0d strobes, required 0", strobes - s0); end
        if (exp_q.size() >= 2) begin
          exp_q.delete(0);
          exp_q.delete(0);
        end
        audio_out_allowed = 1'b1;
      end
    end
    checks++;
    if (strobes - s0 !== 1) begin errors++; $display("FAIL overrun_one_strobe: got %0d, required 1", strobes - s0); end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL overrun_drain: queue not empty, required empty"); end
  endtask

  task automatic test_reset_mid();
    int s0;
    set_all(0, 8'h01, 3'd0);
    voice_in[31:0] = 32'd5;
    audio_out_allowed = 1'b0;
    chk_lat = 1'b0;
    do_reset();
    for (int c = 1; c <= 17; c++) begin
      @(negedge clock);
      if (c == 10) begin
        checks++;
        if (left_audio_out !== 32'd5) begin errors++; $display("FAIL mid_pending: got %0d, required 5", left_audio_out); end
      end
    end
    checks++;
    if (overrun_count !== 8'd1) begin errors++; $display("FAIL mid_overrun_pre: got %0d, required 1", overrun_count); end
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    audio_out_allowed = 1'b1;
    @(negedge clock);
    checks++; if (left_audio_out !== 32'd0) begin errors++; $display("FAIL mid_reset_left: got %0d, required 0", left_audio_out); end
    checks++; if (right_audio_out !== 32'd0) begin errors++; $display("FAIL mid_reset_right: got %0d, required 0", right_audio_out); end
    checks++; if (overrun_count !== 8'd0) begin errors++; $display("FAIL mid_reset_overrun: got %0d, required 0", overrun_count); end
    checks++; if (write_audio_out !== 1'b0) begin errors++; $display("FAIL mid_reset_write: got %b, required 0", write_audio_out); end
    @(negedge clock);
    reset = 1'b0;
    chk_lat = 1'b1;
    s0 = strobes;
    repeat (12) @(negedge clock);
    checks++;
    if (strobes - s0 !== 1) begin errors++; $display("FAIL mid_release_strobes: got %0d, required 1", strobes - s0); end
  endtask

  task automatic test_overrun_sat();
    bit ok;
    int s0;
    set_all(9, 8'h03, 3'd0);
    audio_out_allowed = 1'b0;
    chk_lat = 1'b0;
    do_reset();
    repeat (300 * SD) @(negedge clock);
    checks++;
    if (overrun_count !== 8'd255) begin errors++; $display("FAIL overrun_saturate: got %0d, required 255", overrun_count); end
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    s0 = strobes;
    audio_out_allowed = 1'b1;
    drain(ok);
    checks++;
    if (!ok || strobes - s0 !== 1) begin errors++; $display("FAIL overrun_sat_release: got %0d strobes, required 1", strobes - s0); end
    checks++;
    if (overrun_count !== 8'd255) begin errors++; $display("FAIL overrun_hold: got %0d, required 255", overrun_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_shift_carry();
    test_disabled();
    test_allowed_drop_in_write();
    test_overrun();
    test_reset_mid();
    test_overrun_sat();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
